slicel_cfgchain: RTL and testbench
==================================

Name: slicel_cfgchain

Overview:
- Parametrised logic slice: NUM_LUTS fracturable LUTs, a ripple carry chain, and per-LUT output registers with a per-LUT register/bypass select.
- All configuration loads over one serial scan chain. Slices daisy-chain via config_out.
- Next-generation slice: single clock, synchronous reset, bit counter with config_done flag, and registered/combinational output select.

Parameters:
- K, 4, inputs per LUT half; each LUT takes 2*K address bits.
- NUM_LUTS, 4, LUTs in the slice; also the carry-chain length.
- LB, 2*2**K+2, config bits per LUT (derived; do not override).
- CFG_BITS, NUM_LUTS*LB+1, total slice config bits (derived).

Ports:
- clk  in  1  single clock for config and data registers.
- rst_n  in  1  synchronous reset, active-low.
- luts_in  in  NUM_LUTS*2*K  LUT i address in bits [i*2K +: 2K].
- ci  in  1  carry in.
- reg_ce  in  1  output register clock enable.
- config_en  in  1  shift-enable for the scan chain.
- config_in  in  1  serial config bit.
- config_out  out  1  scan-chain tail, = cfg[CFG_BITS-1].
- config_done  out  1  high once CFG_BITS bits have been shifted since reset.
- co  out  1  carry out.
- out  out  2*NUM_LUTS  slice outputs; LUT i in bits [2i+1:2i].

Behaviour:
- Reset (rst_n=0 at posedge): cfg, bit counter, config_done and all output registers clear to 0. Hence config_out=0, every truth table is 0 and use_cc=0.
- Config shift: on a posedge with config_en=1, cfg <= {cfg[CFG_BITS-2:0], config_in}.
  - Counter increments and saturates at CFG_BITS.
  - config_done is registered: high the cycle after the CFG_BITS-th shift.
  - Further shifting is allowed, overwrites cfg, and keeps config_done=1.
- Config map:
  - cfg[CFG_BITS-1] = use_cc.
  - LUT i uses base b=i*LB: tt_lo=[b +: 2**K], tt_hi=[b+2**K +: 2**K], frac=b+2*2**K, reg_sel=b+2*2**K+1.
- LUT, with a = LUT address (low K bits = a_lo, high K bits = a_hi):
  - frac=1: o[0]=tt_lo[a_lo], o[1]=tt_hi[a_hi].
  - frac=0 (K+1-input LUT): o[0]=o[1]= a[K] ? tt_hi[a_lo] : tt_lo[a_lo].
- Carry chain:
  - P_i = o_i[1], G_i = o_i[0], c_0 = ci.
  - c_{i+1} = G_i | (P_i & c_i), S_i = P_i ^ c_i, co = c_NUM_LUTS.
  - co is always driven, independent of use_cc. It is purely combinational with zero latency.
- comb_i = use_cc ? {P_i, S_i} : o_i.
- Output registers: q_i <= comb_i when reg_ce=1 and config_en=0. config_en forces hold, so registers are frozen while configuring.
- Output mux: out_i = reg_sel_i ? q_i : comb_i.
  - Registered path: 1-cycle latency.
  - Combinational path: 0-cycle latency.
- Reset during a shift: reset wins. cfg and counter clear, and the load restarts from bit 0.
- Reset with reg_ce=1: registers clear.

Optional Feature:
- Macro: SLICEL_SHADOW_CFG_EN.
- Defined:
  - Adds input config_commit.
  - Shifting targets a shadow register; active cfg is unchanged until a posedge with config_commit=1 copies shadow→active.
  - If config_en and config_commit coincide, the pre-shift shadow value is committed.
  - config_out and config_done follow the shadow register.
  - Reset clears both shadow and active.
  - Enables glitch-free reconfiguration while the slice keeps computing; the config_en register freeze still applies.
- Undefined: no config_commit port; shifting writes the active cfg directly, and the logic sees intermediate values while loading.

Decomposition:
- Package slicel_pkg holds:
  - localparam-style functions lut_cfg_bits(K), cfg_bits(K,N);
  - offset constants OFF_TT_LO, OFF_TT_HI, OFF_FRAC, OFF_REGSEL;
  - a typedef for the per-LUT 2-bit output.
- One sub-module, slice_lut_frac: pure combinational fracturable LUT taking tt_lo, tt_hi, frac and a 2K-bit address, returning 2 bits. It is instantiated NUM_LUTS times.
- Carry chain, config chain and registers stay in the top module.

Test Plan (all with K=4, NUM_LUTS=4, CFG_BITS=137):
- Config load: rst_n=0 for one cycle, then 137 cycles of config_en=1 with a random stream.
  - config_done rises exactly after the 137th shift.
  - The first bit shifted in appears on config_out on the 137th cycle.
  - A 138th shift keeps config_done=1.
- AND4 LUT: LUT0 configured with tt_lo=16'h8000, frac=1, reg_sel=0, use_cc=0.
  - luts_in[3:0]=4'hF gives out[0]=1 in the same cycle.
  - luts_in[3:0]=4'hE gives out[0]=0.
- Carry propagate: all LUTs with tt_hi=16'hFFFF, tt_lo=16'h0000, frac=1, use_cc=1.
  - ci=1 gives co=1 and S bits out[6,4,2,0]=0.
  - ci=0 gives co=0 and S=4'b1111.
- Registered output: reg_sel=1 on LUT0.
  - reg_ce=1 pulse updates out[1:0] one cycle later.
  - reg_ce=0 holds the value.
  - rst_n=0 clears it to 0 at the next posedge.
  - config_en=1 blocks an update even with reg_ce=1.
- Unfractured mux: LUT1 with frac=0, tt_lo=16'h0000, tt_hi=16'hFFFF.
  - luts_in bit K of LUT1 = 1 gives out[3:2]=2'b11.
  - That bit = 0 gives out[3:2]=2'b00.
- SLICEL_SHADOW_CFG_EN: shift a new image while out remains at the old function; pulse config_commit; out switches to the new function on the next cycle.

Source files
------------

// File: rtl/slicel_pkg.sv
// Shared types and config-map helpers for the slicel_cfgchain logic slice.
package slicel_pkg;

    typedef logic [1:0] lut_out_t;

    // Field selectors for lut_field_off(); the bit offset itself depends on K.
    localparam int OFF_TT_LO  = 32'd0;
    localparam int OFF_TT_HI  = 32'd1;
    localparam int OFF_FRAC   = 32'd2;
    localparam int OFF_REGSEL = 32'd3;

    function automatic int lut_cfg_bits(input int k);
        return 32'd2 * (32'd1 << k) + 32'd2;
    endfunction

    function automatic int cfg_bits(input int k, input int n);
        return n * lut_cfg_bits(k) + 32'd1;
    endfunction

    function automatic int lut_field_off(input int k, input int field);
        case (field)
            OFF_TT_LO:  return 32'd0;
            OFF_TT_HI:  return (32'd1 << k);
            OFF_FRAC:   return 32'd2 * (32'd1 << k);
            OFF_REGSEL: return 32'd2 * (32'd1 << k) + 32'd1;
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/slicel_cfgchain_lut_frac.sv
// slice_lut_frac: combinational fracturable LUT, two K-input halves or one (K+1)-input LUT.
module slice_lut_frac
    import slicel_pkg::*;
#(
    parameter int K = 4
) (
    input  logic [2**K-1:0] i_tt_lo,
    input  logic [2**K-1:0] i_tt_hi,
    input  logic            i_frac,
    input  logic [2*K-1:0]  i_addr,
    output lut_out_t        o_lut
);

    logic [K-1:0] w_a_lo;
    logic [K-1:0] w_a_hi;
    logic         w_sel;

    assign w_a_lo = i_addr[K-1:0];
    assign w_a_hi = i_addr[2*K-1:K];

    // Table lookup; unfractured mode uses a[K] to pick the half, both outputs equal.
    always_comb begin
        o_lut = 2'b00;
        w_sel = 1'b0;
        if (i_frac) begin
            o_lut = {i_tt_hi[w_a_hi], i_tt_lo[w_a_lo]};
        end else begin
            w_sel = i_addr[K] ? i_tt_hi[w_a_lo] : i_tt_lo[w_a_lo];
            o_lut = {w_sel, w_sel};
        end
    end

endmodule

// File: rtl/slicel_cfgchain.sv
// Logic slice: fracturable LUTs, carry chain, output registers, serial config chain.
// Optional SLICEL_SHADOW_CFG_EN adds config_commit and a shadow config register.
module slicel_cfgchain
    import slicel_pkg::*;
#(
    parameter int K        = 4,
    parameter int NUM_LUTS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_LUTS*2*K-1:0]   luts_in,
    input  logic                      ci,
    input  logic                      reg_ce,
    input  logic                      config_en,
    input  logic                      config_in,
`ifdef SLICEL_SHADOW_CFG_EN
    input  logic                      config_commit,
`endif
    output logic                      config_out,
    output logic                      config_done,
    output logic                      co,
    output logic [2*NUM_LUTS-1:0]     out
);

    localparam int LB       = lut_cfg_bits(K);
    localparam int CFG_BITS = cfg_bits(K, NUM_LUTS);
    localparam int CW       = $clog2(CFG_BITS + 1);
    localparam int TT_W     = 2**K;

    logic [CFG_BITS-1:0] r_shift;
    logic [CFG_BITS-1:0] w_cfg;
    logic [CW-1:0]       r_cnt;
    logic                r_done;
    lut_out_t            w_o    [NUM_LUTS];
    lut_out_t            w_comb [NUM_LUTS];
    lut_out_t            r_q    [NUM_LUTS];

    // Scan chain, load counter and done flag; done sets on the CFG_BITS-th shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (config_en) begin
            r_shift <= {r_shift[CFG_BITS-2:0], config_in};
            if (r_cnt != CW'(CFG_BITS)) begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            if (r_cnt == CW'(CFG_BITS - 1)) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef SLICEL_SHADOW_CFG_EN
    logic [CFG_BITS-1:0] r_cfg;

    // Active image copied from the pre-shift shadow value on commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else if (config_commit) begin
            r_cfg <= r_shift;
        end
    end

    assign w_cfg = r_cfg;
`else
    assign w_cfg = r_shift;
`endif

    assign config_out  = r_shift[CFG_BITS-1];
    assign config_done = r_done;

    for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
        slice_lut_frac #(.K(K)) u_lut (
            .i_tt_lo (w_cfg[g*LB + lut_field_off(K, OFF_TT_LO) +: TT_W]),
            .i_tt_hi (w_cfg[g*LB + lut_field_off(K, OFF_TT_HI) +: TT_W]),
            .i_frac  (w_cfg[g*LB + lut_field_off(K, OFF_FRAC)]),
            .i_addr  (luts_in[g*2*K +: 2*K]),
            .o_lut   (w_o[g])
        );
    end

    // Ripple carry (P = o[1], G = o[0]) and carry-mode output remap.
    always_comb begin : carry_path
        logic v_c;
        v_c    = ci;
        w_comb = '{default: 2'b00};
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (w_cfg[CFG_BITS-1]) begin
                w_comb[i] = {w_o[i][1], w_o[i][1] ^ v_c};
            end else begin
                w_comb[i] = w_o[i];
            end
            v_c = w_o[i][0] | (w_o[i][1] & v_c);
        end
        co = v_c;
    end

    // Output registers, frozen while the config chain is shifting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                r_q[i] <= 2'b00;
            end
        end else if (reg_ce && !config_en) begin
            for (int i = 0; i < NUM_LUTS; i++) begin
                r_q[i] <= w_comb[i];
            end
        end
    end

    // Per-LUT registered/combinational output select.
    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (w_cfg[i*LB + lut_field_off(K, OFF_REGSEL)]) begin
                out[2*i +: 2] = r_q[i];
            end else begin
                out[2*i +: 2] = w_comb[i];
            end
        end
    end

endmodule

// File: tb/tb_slicel_cfgchain.sv
// Directed self-checking bench for slicel_cfgchain (K=4, NUM_LUTS=4, 137 config bits).
module tb_slicel_cfgchain;

    localparam int CB = 137;
    localparam int LB = 34;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] luts_in;
    logic        ci;
    logic        reg_ce;
    logic        config_en;
    logic        config_in;
    logic        config_commit;
    logic        config_out;
    logic        config_done;
    logic        co;
    logic [7:0]  out;

    logic [CB-1:0] img;
    int pass_cnt = 0;
    int total_cnt = 0;

    slicel_cfgchain #(.K(4), .NUM_LUTS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .luts_in     (luts_in),
        .ci          (ci),
        .reg_ce      (reg_ce),
        .config_en   (config_en),
        .config_in   (config_in),
`ifdef SLICEL_SHADOW_CFG_EN
        .config_commit (config_commit),
`endif
        .config_out  (config_out),
        .config_done (config_done),
        .co          (co),
        .out         (out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        total_cnt++;
        if (act !== exp_v) $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
        else pass_cnt++;
    endtask

    task automatic set_lut(input int i, input logic [15:0] lo, input logic [15:0] hi,
                           input logic frac, input logic rsel);
        img[i*LB +: 16]      = lo;
        img[i*LB + 16 +: 16] = hi;
        img[i*LB + 32]       = frac;
        img[i*LB + 33]       = rsel;
    endtask

    task automatic shift_img();
        for (int j = CB - 1; j >= 0; j--) begin
            config_in = img[j];
            config_en = 1'b1;
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic load_img();
        shift_img();
`ifdef SLICEL_SHADOW_CFG_EN
        config_commit = 1'b1;
        tick();
        config_commit = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_config_out", {7'd0, config_out}, 8'h00);
        chk("rst_config_done", {7'd0, config_done}, 8'h00);
        chk("rst_out", out, 8'h00);
        chk("rst_co", {7'd0, co}, 8'h00);
    endtask

    task automatic test_config_load();
        logic first_bit;
        logic second_bit;
        logic b;
        do_reset();
        first_bit = 1'b0;
        second_bit = 1'b0;
        for (int n = 1; n <= 138; n++) begin
            b = 1'($urandom_range(0, 1));
            if (n == 1) first_bit = b;
            if (n == 2) second_bit = b;
            config_in = b;
            config_en = 1'b1;
            tick();
            if (n == 136) begin
                chk("done_before_137", {7'd0, config_done}, 8'h00);
                chk("cfgout_before_137", {7'd0, config_out}, 8'h00);
            end
            if (n == 137) begin
                chk("done_at_137", {7'd0, config_done}, 8'h01);
                chk("cfgout_first_bit", {7'd0, config_out}, {7'd0, first_bit});
            end
            if (n == 138) begin
                chk("done_at_138", {7'd0, config_done}, 8'h01);
                chk("cfgout_second_bit", {7'd0, config_out}, {7'd0, second_bit});
            end
        end
        config_en = 1'b0;
    endtask

    task automatic test_and4();
        img = '0;
        set_lut(0, 16'h8000, 16'h0000, 1'b1, 1'b0);
        luts_in = 32'h0;
        load_img();
        luts_in = 32'h0000_000F;
        #1;
        chk("and4_hit", {6'd0, out[1:0]}, 8'h01);
        luts_in = 32'h0000_000E;
        #1;
        chk("and4_miss", {6'd0, out[1:0]}, 8'h00);
    endtask

    task automatic test_carry();
        img = '0;
        for (int i = 0; i < 4; i++) set_lut(i, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        img[CB-1] = 1'b1;
        load_img();
        luts_in = 32'h1234_5678;
        ci = 1'b1;
        #1;
        chk("carry_ci1_co", {7'd0, co}, 8'h01);
        chk("carry_ci1_out", out, 8'hAA);
        ci = 1'b0;
        #1;
        chk("carry_ci0_co", {7'd0, co}, 8'h00);
        chk("carry_ci0_out", out, 8'hFF);
    endtask

    task automatic test_registered();
        img = '0;
        set_lut(0, 16'h8000, 16'h0000, 1'b1, 1'b1);
        luts_in = 32'h0000_000F;
        ci = 1'b0;
        reg_ce = 1'b0;
        load_img();
        chk("reg_initial", {6'd0, out[1:0]}, 8'h00);
        reg_ce = 1'b1;
        #1;
        chk("reg_no_comb_path", {6'd0, out[1:0]}, 8'h00);
        tick();
        reg_ce = 1'b0;
        chk("reg_update", {6'd0, out[1:0]}, 8'h01);
        luts_in = 32'h0000_000E;
        tick();
        chk("reg_hold", {6'd0, out[1:0]}, 8'h01);
        // One shift keeps reg_sel of LUT0 at 1 (it takes the old frac bit).
        reg_ce = 1'b1;
        config_en = 1'b1;
        config_in = 1'b0;
        tick();
        config_en = 1'b0;
        chk("reg_cfg_freeze", {6'd0, out[1:0]}, 8'h01);
        do_reset();
        reg_ce = 1'b0;
        chk("reg_reset_clear", {6'd0, out[1:0]}, 8'h00);
        chk("reg_reset_done", {7'd0, config_done}, 8'h00);
    endtask

    task automatic test_unfractured();
        img = '0;
        set_lut(1, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        luts_in = 32'h0;
        load_img();
        luts_in = 32'h0000_1000;
        #1;
        chk("unfrac_hi", {6'd0, out[3:2]}, 8'h03);
        luts_in = 32'h0000_0000;
        #1;
        chk("unfrac_lo", {6'd0, out[3:2]}, 8'h00);
        luts_in = 32'h0000_1F00;
        #1;
        chk("unfrac_hi_addr", out, 8'h0C);
    endtask

    task automatic test_reset_mid_shift();
        for (int n = 0; n < 60; n++) begin
            config_in = 1'b1;
            config_en = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_cfgout", {7'd0, config_out}, 8'h00);
        chk("midrst_done", {7'd0, config_done}, 8'h00);
        for (int n = 0; n < 136; n++) begin
            config_in = 1'b0;
            tick();
        end
        chk("midrst_done_136", {7'd0, config_done}, 8'h00);
        tick();
        config_en = 1'b0;
        chk("midrst_done_137", {7'd0, config_done}, 8'h01);
    endtask

`ifdef SLICEL_SHADOW_CFG_EN
    task automatic test_shadow();
        img = '0;
        set_lut(0, 16'h8000, 16'h0000, 1'b1, 1'b0);
        luts_in = 32'h0000_000F;
        load_img();
        chk("shadow_old_fn", {6'd0, out[1:0]}, 8'h01);
        img = '0;
        set_lut(0, 16'h0001, 16'h0000, 1'b1, 1'b0);
        shift_img();
        chk("shadow_hold_old", {6'd0, out[1:0]}, 8'h01);
        config_commit = 1'b1;
        #1;
        chk("shadow_pre_commit", {6'd0, out[1:0]}, 8'h01);
        tick();
        config_commit = 1'b0;
        chk("shadow_new_fn", {6'd0, out[1:0]}, 8'h00);
        luts_in = 32'h0000_0000;
        #1;
        chk("shadow_new_fn_hit", {6'd0, out[1:0]}, 8'h01);
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        luts_in = 32'h0;
        ci = 1'b0;
        reg_ce = 1'b0;
        config_en = 1'b0;
        config_in = 1'b0;
        config_commit = 1'b0;
        img = '0;
        tick();
        test_reset();
        test_config_load();
        test_and4();
        test_carry();
        test_registered();
        test_unfractured();
        test_reset_mid_shift();
`ifdef SLICEL_SHADOW_CFG_EN
        test_shadow();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
